// File: rtl/scaler_vline_dda_pkg.sv
// rtl/scaler_vline_dda_pkg.sv - shared constants and state encoding for the vertical line DDA
package scaler_vline_dda_pkg;

    localparam int FRAC_W  = 17;
    localparam int ILINE_W = 11;
    localparam int ACC_W   = FRAC_W + ILINE_W + 1;
    localparam int STEP_W  = 28;

    localparam logic [ACC_W-1:0] ONE_Q17  = ACC_W'(1) << FRAC_W;
    localparam logic [ACC_W-1:0] HALF_Q17 = ONE_Q17 >> 1;

    typedef enum logic [2:0] {
        ST_VDDA_IDLE,
        ST_VDDA_LOAD,
        ST_VDDA_STEP,
        ST_VDDA_ACTIVE,
        ST_VDDA_DONE
    } vdda_state_e;

endpackage

// File: rtl/vline_dda_map.sv
// rtl/vline_dda_map.sv - accumulator snapshot to source line pair / phase, plus output register
module vline_dda_map
    import scaler_vline_dda_pkg::*;
#(
    parameter int LINE_W  = 10,
    parameter int PHASE_W = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             vld_i,
    input  logic [ILINE_W+PHASE_W:0]         snap_i,
    input  logic [LINE_W-1:0]                vpos_i,
    input  logic [LINE_W-1:0]                needed_i,
    output logic [LINE_W-1:0]                rdline_a_o,
    output logic [LINE_W-1:0]                rdline_b_o,
    output logic [PHASE_W-1:0]               v_phase_o,
    output logic                             line_vld_o
);

    localparam int SNAP_W = ILINE_W + PHASE_W + 1;

    logic [ILINE_W-1:0] last;
    logic [ILINE_W-1:0] iline_raw;
    logic [ILINE_W-1:0] iline;
    logic [ILINE_W-1:0] inext;
    logic [ILINE_W-1:0] iline_b;
    logic [PHASE_W-1:0] phase_raw;
    logic [PHASE_W-1:0] phase;

    always_comb begin
        last      = ILINE_W'(needed_i) - ILINE_W'(1);
        iline_raw = '0;
        phase_raw = '0;
        // Negative accumulator means the sample sits above the first line centre.
        if (!snap_i[SNAP_W-1]) begin
            iline_raw = snap_i[SNAP_W-2:PHASE_W];
            phase_raw = snap_i[PHASE_W-1:0];
        end
        iline = iline_raw;
        phase = phase_raw;
        if (iline_raw > last) begin
            iline = last;
            phase = '0;
        end
        inext   = iline + ILINE_W'(1);
        iline_b = (inext > last) ? last : inext;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdline_a_o <= '0;
            rdline_b_o <= '0;
            v_phase_o  <= '0;
            line_vld_o <= 1'b0;
        end else begin
            line_vld_o <= vld_i;
            if (vld_i) begin
                rdline_a_o <= LINE_W'(ILINE_W'(vpos_i) + iline);
                rdline_b_o <= LINE_W'(ILINE_W'(vpos_i) + iline_b);
                v_phase_o  <= phase;
            end
        end
    end

endmodule

// File: rtl/scaler_vline_dda.sv
// rtl/scaler_vline_dda.sv - per-output-line vertical DDA producing source line pair and blend phase
module scaler_vline_dda
    import scaler_vline_dda_pkg::*;
#(
    parameter int LINE_W  = 10,
    parameter int PHASE_W = 8
) (
    input  logic                VCLK,
    input  logic                VRST,
    input  logic                frame_start_i,
    input  logic                line_req_i,
    input  logic [LINE_W-1:0]   vpos_1st_rdline_i,
    input  logic [LINE_W-1:0]   vlines_in_needed_i,
    input  logic [10:0]         vlines_out_i,
    input  logic [17:0]         v_interp_factor_i,
    output logic [LINE_W-1:0]   rdline_a_o,
    output logic [LINE_W-1:0]   rdline_b_o,
    output logic [PHASE_W-1:0]  v_phase_o,
    output logic                line_vld_o,
    output logic                frame_done_o
);

    localparam int SNAP_W = ILINE_W + PHASE_W + 1;

    vdda_state_e         state_q, state_d;
    logic [LINE_W-1:0]   vpos_q;
    logic [LINE_W-1:0]   needed_q;
    logic [10:0]         vout_q;
    logic [10:0]         cnt_q;
    logic [17:0]         factor_q;
    logic [STEP_W-1:0]   step_q;
    logic [ACC_W-1:0]    acc_q;
    logic [SNAP_W-1:0]   snap_q;
    logic                snap_vld_q;
    logic                accept;

    (* multstyle = "dsp" *) logic [STEP_W-1:0] prod;
    assign prod = STEP_W'(needed_q) * STEP_W'(factor_q);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_VDDA_IDLE:   state_d = ST_VDDA_IDLE;
            ST_VDDA_LOAD: begin
                if (vlines_out_i == '0 || vlines_in_needed_i == '0)
                    state_d = ST_VDDA_DONE;
                else
                    state_d = ST_VDDA_STEP;
            end
            ST_VDDA_STEP:   state_d = ST_VDDA_ACTIVE;
            ST_VDDA_ACTIVE: begin
                if (cnt_q == vout_q)
                    state_d = ST_VDDA_DONE;
                else
                    accept = line_req_i;
            end
            ST_VDDA_DONE:   state_d = ST_VDDA_DONE;
            default:        state_d = ST_VDDA_IDLE;
        endcase
        if (frame_start_i) begin
            state_d = ST_VDDA_LOAD;
            accept  = 1'b0;
        end
    end

    // acc is two's complement in an unsigned register; its MSB is the sign.
    always_ff @(posedge VCLK or posedge VRST) begin
        if (VRST) begin
            state_q    <= ST_VDDA_IDLE;
            vpos_q     <= '0;
            needed_q   <= '0;
            vout_q     <= '0;
            factor_q   <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_vld_q <= accept;
            if (state_q == ST_VDDA_LOAD) begin
                vpos_q   <= vpos_1st_rdline_i;
                needed_q <= vlines_in_needed_i;
                vout_q   <= vlines_out_i;
                factor_q <= v_interp_factor_i;
            end
            if (state_q == ST_VDDA_STEP) begin
                step_q <= prod;
                acc_q  <= ACC_W'(prod >> 1) - HALF_Q17;
                cnt_q  <= '0;
            end
            if (accept) begin
                snap_q <= acc_q[ACC_W-1:FRAC_W-PHASE_W];
                acc_q  <= acc_q + ACC_W'(step_q);
                cnt_q  <= cnt_q + 11'd1;
            end
        end
    end

    assign frame_done_o = (state_q == ST_VDDA_DONE);

    vline_dda_map #(
        .LINE_W  (LINE_W),
        .PHASE_W (PHASE_W)
    ) u_map (
        .clk_i      (VCLK),
        .rst_i      (VRST),
        .vld_i      (snap_vld_q),
        .snap_i     (snap_q),
        .vpos_i     (vpos_q),
        .needed_i   (needed_q),
        .rdline_a_o (rdline_a_o),
        .rdline_b_o (rdline_b_o),
        .v_phase_o  (v_phase_o),
        .line_vld_o (line_vld_o)
    );

endmodule
